// File: rtl/fc_tx_tlp_scheduler.sv
// Credit-gated round-robin TLP scheduler (P/NP/Cpl) that owns the credits-consumed counters.
// One cycle from eligible request to registered grant; a grant holds until tlp_done_i, and blocked types never stall others.
module fc_tx_tlp_scheduler (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        fc_init_done_i,
    input  logic [7:0]  cl_ph_i,
    input  logic [7:0]  cl_nph_i,
    input  logic [7:0]  cl_cplh_i,
    input  logic [11:0] cl_pd_i,
    input  logic [11:0] cl_cpld_i,
    input  logic [2:0]  req_valid_i,
    input  logic [7:0]  p_dcr_i,
    input  logic [7:0]  cpl_dcr_i,
    input  logic        tlp_done_i,
    output logic [2:0]  grant_o,
    output logic [1:0]  send_tlp_type_o,
    output logic [7:0]  cc_ph_o,
    output logic [7:0]  cc_nph_o,
    output logic [7:0]  cc_cplh_o,
    output logic [11:0] cc_pd_o,
    output logic [11:0] cc_cpld_o
);

    typedef enum logic {IDLE = 1'b0, GNT = 1'b1} state_t;

    state_t      r_state, w_state_nxt;
    logic [1:0]  r_ptr, w_ptr_nxt;
    logic [2:0]  r_grant, w_grant_nxt;
    logic [1:0]  r_type, w_type_nxt;
    logic [7:0]  r_cc_ph, r_cc_nph, r_cc_cplh;
    logic [7:0]  w_cc_ph_nxt, w_cc_nph_nxt, w_cc_cplh_nxt;
    logic [11:0] r_cc_pd, r_cc_cpld;
    logic [11:0] w_cc_pd_nxt, w_cc_cpld_nxt;

    logic [7:0]  w_ph_gap, w_nph_gap, w_cplh_gap;
    logic [11:0] w_pd_gap, w_cpld_gap;
    logic [11:0] w_p_dcr, w_cpl_dcr;
    logic [2:0]  w_elig;
    logic [1:0]  w_ord0, w_ord1, w_ord2;
    logic [1:0]  w_win;
    logic        w_win_vld;

    assign w_p_dcr   = {4'd0, p_dcr_i};
    assign w_cpl_dcr = {4'd0, cpl_dcr_i};

    // Modular gaps: a limit that has wrapped past the counter still reads as "ahead" if within half range.
    assign w_ph_gap   = cl_ph_i   - (r_cc_ph   + 8'd1);
    assign w_nph_gap  = cl_nph_i  - (r_cc_nph  + 8'd1);
    assign w_cplh_gap = cl_cplh_i - (r_cc_cplh + 8'd1);
    assign w_pd_gap   = cl_pd_i   - (r_cc_pd   + w_p_dcr);
    assign w_cpld_gap = cl_cpld_i - (r_cc_cpld + w_cpl_dcr);

    assign w_elig[0] = fc_init_done_i & req_valid_i[0] &
                       (w_ph_gap <= 8'd128) & (w_pd_gap <= 12'd2048);
    assign w_elig[1] = fc_init_done_i & req_valid_i[1] & (w_nph_gap <= 8'd128);
    assign w_elig[2] = fc_init_done_i & req_valid_i[2] &
                       (w_cplh_gap <= 8'd128) & (w_cpld_gap <= 12'd2048);

    always_comb begin
        w_ord0 = 2'd0;
        w_ord1 = 2'd1;
        w_ord2 = 2'd2;
        case (r_ptr)
            2'd0: begin w_ord0 = 2'd1; w_ord1 = 2'd2; w_ord2 = 2'd0; end
            2'd1: begin w_ord0 = 2'd2; w_ord1 = 2'd0; w_ord2 = 2'd1; end
            default: ;
        endcase
    end

    assign w_win_vld = |w_elig;
    assign w_win     = w_elig[w_ord0] ? w_ord0 :
                       w_elig[w_ord1] ? w_ord1 : w_ord2;

    always_comb begin
        w_state_nxt   = r_state;
        w_ptr_nxt     = r_ptr;
        w_grant_nxt   = r_grant;
        w_type_nxt    = r_type;
        w_cc_ph_nxt   = r_cc_ph;
        w_cc_nph_nxt  = r_cc_nph;
        w_cc_cplh_nxt = r_cc_cplh;
        w_cc_pd_nxt   = r_cc_pd;
        w_cc_cpld_nxt = r_cc_cpld;
        case (r_state)
            IDLE: begin
                if (w_win_vld) begin
                    w_state_nxt = GNT;
                    w_ptr_nxt   = w_win;
                    case (w_win)
                        2'd0: begin
                            w_grant_nxt = 3'b001;
                            w_type_nxt  = 2'b00;
                            w_cc_ph_nxt = r_cc_ph + 8'd1;
                            w_cc_pd_nxt = r_cc_pd + w_p_dcr;
                        end
                        2'd1: begin
                            w_grant_nxt  = 3'b010;
                            w_type_nxt   = 2'b01;
                            w_cc_nph_nxt = r_cc_nph + 8'd1;
                        end
                        default: begin
                            w_grant_nxt   = 3'b100;
                            w_type_nxt    = 2'b10;
                            w_cc_cplh_nxt = r_cc_cplh + 8'd1;
                            w_cc_cpld_nxt = r_cc_cpld + w_cpl_dcr;
                        end
                    endcase
                end
            end
            GNT: begin
                if (tlp_done_i) begin
                    w_state_nxt = IDLE;
                    w_grant_nxt = 3'b000;
                    w_type_nxt  = 2'b11;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= IDLE;
            r_ptr     <= 2'd2;
            r_grant   <= 3'b000;
            r_type    <= 2'b11;
            r_cc_ph   <= 8'd0;
            r_cc_nph  <= 8'd0;
            r_cc_cplh <= 8'd0;
            r_cc_pd   <= 12'd0;
            r_cc_cpld <= 12'd0;
        end else begin
            r_state   <= w_state_nxt;
            r_ptr     <= w_ptr_nxt;
            r_grant   <= w_grant_nxt;
            r_type    <= w_type_nxt;
            r_cc_ph   <= w_cc_ph_nxt;
            r_cc_nph  <= w_cc_nph_nxt;
            r_cc_cplh <= w_cc_cplh_nxt;
            r_cc_pd   <= w_cc_pd_nxt;
            r_cc_cpld <= w_cc_cpld_nxt;
        end
    end

    assign grant_o         = r_grant;
    assign send_tlp_type_o = r_type;
    assign cc_ph_o         = r_cc_ph;
    assign cc_nph_o        = r_cc_nph;
    assign cc_cplh_o       = r_cc_cplh;
    assign cc_pd_o         = r_cc_pd;
    assign cc_cpld_o       = r_cc_cpld;

endmodule

// File: tb/tb_fc_tx_tlp_scheduler.sv
// Bench for fc_tx_tlp_scheduler: directed credit/arbitration scenarios plus random traffic,
// every cycle compared against a transaction-level credit model.
module tb_fc_tx_tlp_scheduler;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        fc_init_done_i = 1'b0;
    logic [7:0]  cl_ph_i = '0, cl_nph_i = '0, cl_cplh_i = '0;
    logic [11:0] cl_pd_i = '0, cl_cpld_i = '0;
    logic [2:0]  req_valid_i = '0;
    logic [7:0]  p_dcr_i = '0, cpl_dcr_i = '0;
    logic        tlp_done_i = 1'b0;
    logic [2:0]  grant_o;
    logic [1:0]  send_tlp_type_o;
    logic [7:0]  cc_ph_o, cc_nph_o, cc_cplh_o;
    logic [11:0] cc_pd_o, cc_cpld_o;

    fc_tx_tlp_scheduler dut (
        .clk(clk), .rst_n(rst_n), .fc_init_done_i(fc_init_done_i),
        .cl_ph_i(cl_ph_i), .cl_nph_i(cl_nph_i), .cl_cplh_i(cl_cplh_i),
        .cl_pd_i(cl_pd_i), .cl_cpld_i(cl_cpld_i), .req_valid_i(req_valid_i),
        .p_dcr_i(p_dcr_i), .cpl_dcr_i(cpl_dcr_i), .tlp_done_i(tlp_done_i),
        .grant_o(grant_o), .send_tlp_type_o(send_tlp_type_o),
        .cc_ph_o(cc_ph_o), .cc_nph_o(cc_nph_o), .cc_cplh_o(cc_cplh_o),
        .cc_pd_o(cc_pd_o), .cc_cpld_o(cc_cpld_o)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // Model: consumed credits per pool (ph, nph, cplh, pd, cpld), busy flag, current and last winner.
    int m_cc[5];
    bit m_busy;
    int m_cur;
    int m_last;

    logic [2:0] g_log[$];
    logic [2:0] prev_g;
    int         n_gnt;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic bit hdr_ok(input int cl, input int cc);
        return ((cl - cc - 1) & 255) <= 128;
    endfunction

    function automatic bit dat_ok(input int cl, input int cc, input int dcr);
        return ((cl - cc - dcr) & 4095) <= 2048;
    endfunction

    function automatic bit m_elig(input int t);
        if (!fc_init_done_i || !req_valid_i[t]) return 1'b0;
        case (t)
            0:       return hdr_ok(int'(cl_ph_i), m_cc[0]) && dat_ok(int'(cl_pd_i), m_cc[3], int'(p_dcr_i));
            1:       return hdr_ok(int'(cl_nph_i), m_cc[1]);
            default: return hdr_ok(int'(cl_cplh_i), m_cc[2]) && dat_ok(int'(cl_cpld_i), m_cc[4], int'(cpl_dcr_i));
        endcase
    endfunction

    task automatic model_reset();
        m_busy = 1'b0;
        m_cur  = 3;
        m_last = 2;
        for (int i = 0; i < 5; i++) m_cc[i] = 0;
    endtask

    task automatic model_tick();
        bit found;
        int t;
        found = 1'b0;
        if (m_busy) begin
            if (tlp_done_i) m_busy = 1'b0;
        end else begin
            for (int k = 1; k <= 3; k++) begin
                t = (m_last + k) % 3;
                if (!found && m_elig(t)) begin
                    found = 1'b1;
                    m_cur = t;
                end
            end
            if (found) begin
                m_busy = 1'b1;
                m_last = m_cur;
                if (m_cur == 0) begin
                    m_cc[0] = (m_cc[0] + 1) & 255;
                    m_cc[3] = (m_cc[3] + int'(p_dcr_i)) & 4095;
                end else if (m_cur == 1) begin
                    m_cc[1] = (m_cc[1] + 1) & 255;
                end else begin
                    m_cc[2] = (m_cc[2] + 1) & 255;
                    m_cc[4] = (m_cc[4] + int'(cpl_dcr_i)) & 4095;
                end
            end
        end
    endtask

    task automatic compare_all();
        check_eq("grant",   32'(grant_o),         m_busy ? (32'd1 << m_cur) : 32'd0);
        check_eq("type",    32'(send_tlp_type_o), m_busy ? m_cur : 3);
        check_eq("cc_ph",   32'(cc_ph_o),   m_cc[0]);
        check_eq("cc_nph",  32'(cc_nph_o),  m_cc[1]);
        check_eq("cc_cplh", 32'(cc_cplh_o), m_cc[2]);
        check_eq("cc_pd",   32'(cc_pd_o),   m_cc[3]);
        check_eq("cc_cpld", 32'(cc_cpld_o), m_cc[4]);
    endtask

    // Inputs are stable from the previous falling edge; outputs are sampled on the next one.
    task automatic step();
        model_tick();
        @(posedge clk);
        @(negedge clk);
        compare_all();
        if (grant_o != 3'b000 && prev_g == 3'b000) begin
            n_gnt++;
            g_log.push_back(grant_o);
        end
        prev_g = grant_o;
    endtask

    task automatic run(input int n, input bit rnd_done);
        for (int i = 0; i < n; i++) begin
            tlp_done_i = (grant_o != 3'b000) && (!rnd_done || $urandom_range(0, 2) == 0);
            step();
        end
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        #1;
        model_reset();
        check_eq("rst_grant",   32'(grant_o),         32'd0);
        check_eq("rst_type",    32'(send_tlp_type_o), 32'd3);
        check_eq("rst_cc_ph",   32'(cc_ph_o),   32'd0);
        check_eq("rst_cc_nph",  32'(cc_nph_o),  32'd0);
        check_eq("rst_cc_cplh", 32'(cc_cplh_o), 32'd0);
        check_eq("rst_cc_pd",   32'(cc_pd_o),   32'd0);
        check_eq("rst_cc_cpld", 32'(cc_cpld_o), 32'd0);
        @(negedge clk);
        rst_n      = 1'b1;
        tlp_done_i = 1'b0;
        prev_g     = 3'b000;
        n_gnt      = 0;
        g_log.delete();
    endtask

    task automatic set_ample();
        cl_ph_i = 8'h80; cl_nph_i = 8'h80; cl_cplh_i = 8'h80;
        cl_pd_i = 12'h800; cl_cpld_i = 12'h800;
        p_dcr_i = 8'd1; cpl_dcr_i = 8'd1;
    endtask

    task automatic wrap_run(input int t);
        int guard;
        guard = 0;
        do_reset();
        fc_init_done_i = 1'b1;
        req_valid_i = (t == 0) ? 3'b001 : 3'b100;
        p_dcr_i = 8'd0;  cl_pd_i = 12'd0;
        cpl_dcr_i = 8'd16; cl_cpld_i = 12'd16;
        cl_ph_i = 8'd1; cl_cplh_i = 8'd1; cl_nph_i = 8'd0;
        while (n_gnt < 260 && guard < 1200) begin
            tlp_done_i = (grant_o != 3'b000);
            if (grant_o != 3'b000) begin
                cl_ph_i   = cl_ph_i + 8'd1;
                cl_cplh_i = cl_cplh_i + 8'd1;
                cl_cpld_i = cl_cpld_i + 12'd16;
            end
            step();
            guard++;
        end
        run(8, 1'b0);
        check_eq("wrap_grants", n_gnt, 260);
        if (t == 0) begin
            check_eq("wrap_cc_ph", 32'(cc_ph_o), 32'd4);
        end else begin
            check_eq("wrap_cc_cplh", 32'(cc_cplh_o), 32'd4);
            check_eq("wrap_cc_cpld", 32'(cc_cpld_o), 32'd64);
        end
    endtask

    function automatic int hoff();
        case ($urandom_range(0, 5))
            0: return 0;
            1: return 1;
            2: return 2;
            3: return 129;
            4: return 130;
            default: return int'($urandom_range(0, 255));
        endcase
    endfunction

    function automatic int doff();
        case ($urandom_range(0, 5))
            0: return -1;
            1: return 0;
            2: return 1;
            3: return 2048;
            4: return 2049;
            default: return int'($urandom_range(0, 4095));
        endcase
    endfunction

    logic [2:0] rr_exp[6];
    logic [2:0] rr_blk_exp[3];

    initial begin
        rr_exp     = '{3'b001, 3'b010, 3'b100, 3'b001, 3'b010, 3'b100};
        rr_blk_exp = '{3'b001, 3'b100, 3'b001};
        prev_g = 3'b000;
        n_gnt  = 0;
        model_reset();

        // Header credit limit
        do_reset();
        fc_init_done_i = 1'b1;
        cl_ph_i = 8'h04; cl_pd_i = 12'h000; p_dcr_i = 8'd0; req_valid_i = 3'b001;
        run(20, 1'b0);
        check_eq("hdr_grants", n_gnt, 4);
        check_eq("hdr_cc_ph", 32'(cc_ph_o), 32'd4);
        cl_ph_i = 8'h05;
        tlp_done_i = 1'b0;
        step();
        step();
        check_eq("hdr_regrant", 32'(grant_o), 32'b001);
        check_eq("hdr_cc_ph5", 32'(cc_ph_o), 32'd5);

        // Data credit limit, NP unaffected
        do_reset();
        fc_init_done_i = 1'b1;
        cl_ph_i = 8'h20; cl_pd_i = 12'h010; p_dcr_i = 8'd8; cl_nph_i = 8'h00;
        req_valid_i = 3'b001;
        run(20, 1'b0);
        check_eq("dat_grants", n_gnt, 2);
        check_eq("dat_cc_pd", 32'(cc_pd_o), 32'h010);
        cl_nph_i = 8'h20; req_valid_i = 3'b011; n_gnt = 0; g_log.delete();
        run(10, 1'b0);
        check_eq("dat_np_grants", n_gnt, 5);
        check_eq("dat_np_cc_nph", 32'(cc_nph_o), 32'd5);
        check_eq("dat_np_cc_pd", 32'(cc_pd_o), 32'h010);

        // Round robin, all eligible
        do_reset();
        fc_init_done_i = 1'b1; set_ample(); req_valid_i = 3'b111;
        run(12, 1'b0);
        check_eq("rr_count", g_log.size(), 6);
        for (int i = 0; i < 6 && i < g_log.size(); i++) check_eq("rr_order", 32'(g_log[i]), 32'(rr_exp[i]));

        // Round robin with NP blocked
        do_reset();
        fc_init_done_i = 1'b1; set_ample(); cl_nph_i = 8'h00; req_valid_i = 3'b111;
        run(6, 1'b0);
        check_eq("rr_blk_count", g_log.size(), 3);
        for (int i = 0; i < 3 && i < g_log.size(); i++) check_eq("rr_blk_order", 32'(g_log[i]), 32'(rr_blk_exp[i]));

        // Counter wrap
        wrap_run(0);
        wrap_run(2);

        // Init gating
        do_reset();
        fc_init_done_i = 1'b0; set_ample(); req_valid_i = 3'b111;
        run(10, 1'b1);
        check_eq("init_gate_grants", n_gnt, 0);

        // Reset during an active grant
        fc_init_done_i = 1'b1; req_valid_i = 3'b010; tlp_done_i = 1'b0;
        step();
        check_eq("mid_grant_np", 32'(grant_o), 32'b010);
        do_reset();
        fc_init_done_i = 1'b1; set_ample(); req_valid_i = 3'b111;
        step();
        check_eq("post_rst_first_p", 32'(grant_o), 32'b001);

        // Random traffic around the credit boundaries
        do_reset();
        for (int i = 0; i < 3000; i++) begin
            fc_init_done_i = ($urandom_range(0, 15) != 0);
            req_valid_i = 3'($urandom_range(0, 7));
            p_dcr_i   = 8'($urandom_range(0, 20));
            cpl_dcr_i = 8'($urandom_range(0, 20));
            cl_ph_i   = 8'(m_cc[0] + hoff());
            cl_nph_i  = 8'(m_cc[1] + hoff());
            cl_cplh_i = 8'(m_cc[2] + hoff());
            cl_pd_i   = 12'(m_cc[3] + int'(p_dcr_i) + doff());
            cl_cpld_i = 12'(m_cc[4] + int'(cpl_dcr_i) + doff());
            tlp_done_i = (grant_o != 3'b000) && ($urandom_range(0, 2) == 0);
            step();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
